// File: rtl/adc_avg_decimator.sv
// ---------------------------------------------------------------------------
// adc_avg_decimator
//   Block-averages 2^L consecutive signed ADC samples into one output sample
//   (boxcar decimation by 2^L) and frames the output stream with tlast every
//   cfg_frame_len outputs.
//
// Ports
//   aclk, aresetn   clock, asynchronous active-low reset
//   cfg_enable      1 = average and emit, 0 = drop input and clear accumulation
//   cfg_log2_avg    averaging exponent L (clamped to MAX_LOG2)
//   cfg_frame_len   outputs per frame (0 behaves as 1)
//   s_axis_*        32-bit conversion words, sample in [IN_WIDTH-1:0]
//   m_axis_*        averaged sample, sign-extended to 32 bits, framed by tlast
//   overrun         sticky: a closing sample was stalled by a full output reg
// ---------------------------------------------------------------------------
module adc_avg_decimator #(
   parameter int IN_WIDTH = 24,
   parameter int MAX_LOG2 = 8
) (
   input  logic        aclk,
   input  logic        aresetn,
   input  logic        cfg_enable,
   input  logic [3:0]  cfg_log2_avg,
   input  logic [15:0] cfg_frame_len,
   input  logic [31:0] s_axis_tdata,
   input  logic        s_axis_tvalid,
   output logic        s_axis_tready,
   output logic [31:0] m_axis_tdata,
   output logic        m_axis_tvalid,
   input  logic        m_axis_tready,
   output logic        m_axis_tlast,
   output logic        overrun
);

   localparam int ACC_W = IN_WIDTH + MAX_LOG2;
   localparam int CNT_W = (MAX_LOG2 > 0) ? MAX_LOG2 : 1;

   logic [3:0]              l_lat;
   logic [CNT_W-1:0]        cnt;
   logic signed [ACC_W-1:0] acc;
   logic [15:0]             frame_cnt;
   logic [15:0]             frame_len_lat;

   logic [3:0]              l_cfg;
   logic [3:0]              l_eff;
   logic [CNT_W-1:0]        block_max;
   logic                    block_last;
   logic                    accept;
   logic                    close_blk;
   logic signed [ACC_W-1:0] x_ext;
   logic signed [ACC_W-1:0] sum;
   logic signed [ACC_W-1:0] avg;
   logic [31:0]             result;
   logic [15:0]             frame_len_eff;
   logic                    frame_end;
   logic                    unused_bits;

   assign l_cfg = (cfg_log2_avg > 4'(MAX_LOG2)) ? 4'(MAX_LOG2) : cfg_log2_avg;

   // The first sample of a block is the one that latches L, so that sample
   // must already be judged against the incoming configuration (L=0 closes
   // the block on its very first sample).
   assign l_eff      = (cnt == '0) ? l_cfg : l_lat;
   assign block_max  = CNT_W'((32'd1 << l_eff) - 32'd1);
   assign block_last = (cnt == block_max);

   assign s_axis_tready = cfg_enable ? !(block_last && m_axis_tvalid && !m_axis_tready) : 1'b1;
   assign accept        = s_axis_tvalid && s_axis_tready;
   assign close_blk     = cfg_enable && accept && block_last;

   assign x_ext  = {{MAX_LOG2{s_axis_tdata[IN_WIDTH-1]}}, s_axis_tdata[IN_WIDTH-1:0]};
   assign sum    = ((cnt == '0) ? '0 : acc) + x_ext;
   assign avg    = sum >>> l_eff;
   // The average of IN_WIDTH-bit samples always fits in IN_WIDTH bits.
   assign result = {{(32-IN_WIDTH){avg[IN_WIDTH-1]}}, avg[IN_WIDTH-1:0]};

   // Frame length is captured at the start of each frame; the first output of
   // a frame must therefore use the live configuration.
   assign frame_len_eff = (frame_cnt == 16'd0) ?
                          ((cfg_frame_len == 16'd0) ? 16'd1 : cfg_frame_len) :
                          frame_len_lat;
   assign frame_end     = (frame_cnt == frame_len_eff - 16'd1);

   assign unused_bits = &{1'b0, s_axis_tdata[31:IN_WIDTH], avg[ACC_W-1:IN_WIDTH]};

   // NOTE: state uses non-blocking assignments so every flop samples the
   // pre-edge values of the others, independent of statement order.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         l_lat         <= '0;
         cnt           <= '0;
         acc           <= '0;
         frame_cnt     <= '0;
         frame_len_lat <= '0;
         m_axis_tdata  <= '0;
         m_axis_tvalid <= 1'b0;
         m_axis_tlast  <= 1'b0;
         overrun       <= 1'b0;
      end else begin
         if (s_axis_tvalid && !s_axis_tready)
            overrun <= 1'b1;

         if (!cfg_enable) begin
            cnt       <= '0;
            acc       <= '0;
            frame_cnt <= '0;
         end else if (accept) begin
            if (cnt == '0)
               l_lat <= l_cfg;
            acc <= sum;
            cnt <= block_last ? '0 : cnt + 1'b1;
         end

         // A block can only close when the output reg is empty or draining
         // this cycle, so a load never overwrites an undelivered sample.
         if (close_blk) begin
            m_axis_tdata  <= result;
            m_axis_tvalid <= 1'b1;
            m_axis_tlast  <= frame_end;
            if (frame_cnt == 16'd0)
               frame_len_lat <= frame_len_eff;
            frame_cnt <= frame_end ? 16'd0 : frame_cnt + 16'd1;
         end else if (m_axis_tvalid && m_axis_tready) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_adc_avg_decimator.sv
// ---------------------------------------------------------------------------
// tb_adc_avg_decimator
//   Self-checking bench: a vector table for streaming cases plus hand-written
//   sequences for back-pressure, config latching, enable and reset corners.
//   Expected outputs are queued when stimulus is driven and compared by a
//   monitor at each output handshake.
// ---------------------------------------------------------------------------
module tb_adc_avg_decimator;

   logic        aclk = 1'b0;
   logic        aresetn;
   logic        cfg_enable;
   logic [3:0]  cfg_log2_avg;
   logic [15:0] cfg_frame_len;
   logic [31:0] s_axis_tdata;
   logic        s_axis_tvalid;
   logic        s_axis_tready;
   logic [31:0] m_axis_tdata;
   logic        m_axis_tvalid;
   logic        m_axis_tready;
   logic        m_axis_tlast;
   logic        overrun;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [31:0] data;
      logic        last;
   } exp_t;

   typedef struct {
      logic [3:0]  l;
      logic [15:0] fl;
      logic [31:0] data;
      bit          push;
      logic [31:0] exp_data;
      logic        exp_last;
   } vec_t;

   exp_t exp_q[$];
   vec_t vecs[16];

   adc_avg_decimator dut (
      .aclk          (aclk),
      .aresetn       (aresetn),
      .cfg_enable    (cfg_enable),
      .cfg_log2_avg  (cfg_log2_avg),
      .cfg_frame_len (cfg_frame_len),
      .s_axis_tdata  (s_axis_tdata),
      .s_axis_tvalid (s_axis_tvalid),
      .s_axis_tready (s_axis_tready),
      .m_axis_tdata  (m_axis_tdata),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tready (m_axis_tready),
      .m_axis_tlast  (m_axis_tlast),
      .overrun       (overrun)
   );

   always #5 aclk = ~aclk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
      end
   endtask

   // Output monitor: inputs change just after posedge, so the negedge sees
   // exactly the values the next posedge will act on.
   always @(negedge aclk) begin
      if (aresetn && m_axis_tvalid && m_axis_tready) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_output actual=0x%08h expected=none", m_axis_tdata);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("out_data", m_axis_tdata, e.data);
            check("out_last", 32'(m_axis_tlast), 32'(e.last));
         end
      end
   end

   task automatic send(input logic [31:0] d);
      bit ok;
      ok            = 1'b0;
      s_axis_tdata  = d;
      s_axis_tvalid = 1'b1;
      for (int i = 0; i < 200; i++) begin
         @(negedge aclk);
         if (s_axis_tready) begin
            @(posedge aclk);
            #1;
            ok = 1'b1;
            break;
         end
      end
      s_axis_tvalid = 1'b0;
      if (!ok) begin
         checks++;
         errors++;
         $display("FAIL send_timeout actual=stalled expected=accepted data=0x%08h", d);
      end
   endtask

   task automatic wait_empty();
      for (int i = 0; i < 100 && exp_q.size() != 0; i++)
         @(posedge aclk);
      #1;
      check("queue_drained", 32'(exp_q.size()), 32'd0);
   endtask

   task automatic push_exp(input logic [31:0] d, input logic last);
      exp_t e;
      e.data = d;
      e.last = last;
      exp_q.push_back(e);
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, "_tvalid"}, 32'(m_axis_tvalid), 32'd0);
      check({tag, "_tdata"},  m_axis_tdata, 32'd0);
      check({tag, "_tlast"},  32'(m_axis_tlast), 32'd0);
      check({tag, "_overrun"}, 32'(overrun), 32'd0);
      check({tag, "_tready"}, 32'(s_axis_tready), 32'd1);
   endtask

   task automatic do_reset();
      aresetn = 1'b0;
      exp_q.delete();
      #2;
      check_reset_state("reset");
      @(negedge aclk);
      aresetn = 1'b1;
      @(posedge aclk);
      #1;
   endtask

   initial begin
      aresetn       = 1'b0;
      cfg_enable    = 1'b1;
      cfg_log2_avg  = 4'd0;
      cfg_frame_len = 16'd4;
      s_axis_tdata  = '0;
      s_axis_tvalid = 1'b0;
      m_axis_tready = 1'b1;

      //          L     frame  sample          push  expected       last
      vecs[0]  = '{4'd0, 16'd4, 32'd5,          1, 32'd5,          1'b0};
      vecs[1]  = '{4'd0, 16'd4, 32'hFFFF_FFFD,  1, 32'hFFFF_FFFD,  1'b0};
      vecs[2]  = '{4'd0, 16'd4, 32'd7,          1, 32'd7,          1'b0};
      vecs[3]  = '{4'd0, 16'd4, 32'h007F_FFFF,  1, 32'h007F_FFFF,  1'b1};
      vecs[4]  = '{4'd2, 16'd4, 32'd10,         0, 32'd0,          1'b0};
      vecs[5]  = '{4'd2, 16'd4, 32'd11,         0, 32'd0,          1'b0};
      vecs[6]  = '{4'd2, 16'd4, 32'd12,         0, 32'd0,          1'b0};
      vecs[7]  = '{4'd2, 16'd4, 32'd13,         1, 32'd11,         1'b0};
      vecs[8]  = '{4'd2, 16'd4, 32'hFFFF_FFFF,  0, 32'd0,          1'b0};
      vecs[9]  = '{4'd2, 16'd4, 32'hFFFF_FFFF,  0, 32'd0,          1'b0};
      vecs[10] = '{4'd2, 16'd4, 32'hFFFF_FFFF,  0, 32'd0,          1'b0};
      vecs[11] = '{4'd2, 16'd4, 32'hFFFF_FFFE,  1, 32'hFFFF_FFFE,  1'b0};
      vecs[12] = '{4'd0, 16'd4, 32'h0080_0000,  1, 32'hFF80_0000,  1'b0};
      vecs[13] = '{4'd0, 16'd4, 32'hAB00_0001,  1, 32'd1,          1'b1};
      vecs[14] = '{4'd0, 16'd0, 32'd3,          1, 32'd3,          1'b1};
      vecs[15] = '{4'd0, 16'd0, 32'h00FF_FFFF,  1, 32'hFFFF_FFFF,  1'b1};

      #12;
      check_reset_state("por");
      @(negedge aclk);
      aresetn = 1'b1;
      @(posedge aclk);
      #1;

      // Streaming vectors, tready held high: each closing sample must show up
      // on the output reg one edge after it is accepted.
      foreach (vecs[i]) begin
         cfg_log2_avg  = vecs[i].l;
         cfg_frame_len = vecs[i].fl;
         if (vecs[i].push)
            push_exp(vecs[i].exp_data, vecs[i].exp_last);
         send(vecs[i].data);
         if (vecs[i].push) begin
            check("latency_valid", 32'(m_axis_tvalid), 32'd1);
            check("latency_data", m_axis_tdata, vecs[i].exp_data);
         end
      end
      wait_empty();

      // Back-pressure: second block's closing sample stalls and flags overrun.
      do_reset();
      cfg_log2_avg  = 4'd2;
      cfg_frame_len = 16'd4;
      m_axis_tready = 1'b0;
      push_exp(32'd2, 1'b0);
      for (int i = 1; i <= 4; i++) send(32'(i));
      check("hold_valid", 32'(m_axis_tvalid), 32'd1);
      check("hold_data", m_axis_tdata, 32'd2);
      for (int i = 5; i <= 7; i++) send(32'(i));
      check("hold_data_later", m_axis_tdata, 32'd2);
      check("no_overrun_yet", 32'(overrun), 32'd0);
      s_axis_tdata  = 32'd8;
      s_axis_tvalid = 1'b1;
      @(negedge aclk);
      check("stall_tready", 32'(s_axis_tready), 32'd0);
      @(posedge aclk);
      #1;
      check("overrun_set", 32'(overrun), 32'd1);
      check("stall_hold_data", m_axis_tdata, 32'd2);
      push_exp(32'd6, 1'b0);
      m_axis_tready = 1'b1;
      @(posedge aclk);
      #1;
      s_axis_tvalid = 1'b0;
      check("second_block_loaded", m_axis_tdata, 32'd6);
      wait_empty();
      check("overrun_sticky", 32'(overrun), 32'd1);

      // L changes 1->3 after the first sample of a block.
      do_reset();
      cfg_log2_avg = 4'd1;
      push_exp(32'd150, 1'b0);
      send(32'd100);
      cfg_log2_avg = 4'd3;
      send(32'd200);
      push_exp(32'd4, 1'b0);
      for (int i = 1; i <= 7; i++) send(32'(i));
      check("l8_not_early", 32'(exp_q.size() != 0 || m_axis_tvalid), 32'd1);
      send(32'd8);
      wait_empty();

      // Enable dropped mid-block: partial block vanishes.
      do_reset();
      cfg_log2_avg = 4'd2;
      for (int i = 1; i <= 3; i++) send(32'(i));
      cfg_enable = 1'b0;
      @(negedge aclk);
      check("disabled_tready", 32'(s_axis_tready), 32'd1);
      send(32'd99);
      @(posedge aclk);
      #1;
      check("disabled_no_output", 32'(m_axis_tvalid), 32'd0);
      cfg_enable = 1'b1;
      push_exp(32'd21, 1'b0);
      for (int i = 20; i <= 23; i++) send(32'(i));
      wait_empty();

      // Clamp: L=12 behaves as 8 (256-sample block).
      do_reset();
      cfg_log2_avg  = 4'd12;
      cfg_frame_len = 16'd0;
      push_exp(32'd127, 1'b1);
      for (int i = 0; i < 256; i++) send(32'(i));
      wait_empty();

      // Reset with an output pending and cnt=2.
      do_reset();
      cfg_log2_avg  = 4'd2;
      cfg_frame_len = 16'd4;
      m_axis_tready = 1'b0;
      for (int i = 1; i <= 6; i++) send(32'(i));
      check("pre_reset_pending", 32'(m_axis_tvalid), 32'd1);
      do_reset();
      cfg_log2_avg  = 4'd0;
      cfg_frame_len = 16'd2;
      m_axis_tready = 1'b1;
      push_exp(32'd9, 1'b0);
      send(32'd9);
      check("post_reset_first", m_axis_tdata, 32'd9);
      push_exp(32'hFFFF_FFF7, 1'b1);
      send(32'hFFFF_FFF7);
      wait_empty();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
